issue_scoreboard: RTL and testbench
===================================

Name: issue_scoreboard

Overview:
- Sits between decode and execute; holds one decoded superscalar bundle and releases slots in program order only when they are hazard-free.
- Tracks a busy bit per architectural register: set at issue, cleared at writeback.
- Stalls RAW and WAW hazards, both against in-flight instructions and within the bundle.
- Keeps a saturating stall-cycle counter for performance analysis.

Parameters:
- WIDTH, 2, slots per bundle; equals SUPER_SCALAR_WIDTH.
- REG_BITS, 6, register index width.
- NUM_REGS, 64, architectural registers; register 0 is hardwired zero.
- WB_PORTS, 2, writeback clear ports.
- CNT_BITS, 16, stall counter width.

Ports:
- clk_in  in  1  clock.
- rst_in  in  1  reset; asynchronous, active-low.
- decode_valid_in  in  1  bundle offered by decode.
- decode_ready_out  out  1  bundle accepted on valid&&ready.
- dec_slot_valid_in  in  WIDTH  slot i holds a real instruction.
- dec_dst_in  in  WIDTH*REG_BITS  destination register, slot i at [i*REG_BITS +: REG_BITS].
- dec_src1_in  in  WIDTH*REG_BITS  source register 1.
- dec_src2_in  in  WIDTH*REG_BITS  source register 2.
- dec_use_mask_in  in  WIDTH*3  per slot {writes_dst, uses_src2, uses_src1}.
- issue_ready_in  in  1  execute accepts.
- issue_valid_out  out  1  at least one slot issuing.
- issue_mask_out  out  WIDTH  slots issuing this handshake; always a contiguous prefix of the pending slots.
- issue_dst_out, issue_src1_out, issue_src2_out  out  WIDTH*REG_BITS  registered copies of the held bundle.
- wb_valid_in  in  WB_PORTS  writeback strobes.
- wb_reg_in  in  WB_PORTS*REG_BITS  writeback registers.
- flush_in  in  1  discard the held bundle.
- busy_out  out  NUM_REGS  scoreboard state.
- stall_count_out  out  CNT_BITS  stall cycles.

Behaviour:
Reset (rst_in low, asynchronous):
- pending mask = 0, busy = 0, stall_count_out = 0.
- Held fields = 0, so issue_valid_out = 0 and issue_mask_out = 0.
- decode_ready_out = 1 once reset is released.

Accept:
- decode_ready_out = (pending == 0) || (issue handshake this cycle && issue_mask_out == pending).
- On decode_valid_in && decode_ready_out, register all fields; pending <= dec_slot_valid_in.
- Issue of the newly accepted bundle can begin no earlier than the next cycle (minimum latency 1).
- A bundle with dec_slot_valid_in == 0 is accepted and dropped.

Hazard check (combinational, uses the registered busy only; no writeback bypass):
- Slot i is clean if it is pending and:
  - each used source is 0 or not busy;
  - a written dst is 0 or not busy;
  - no earlier pending slot j<i writes a nonzero register equal to slot i's used source or written dst.
- issue_mask_out = longest run of clean pending slots starting at the lowest-indexed pending slot. Gaps are never skipped.
- issue_valid_out = |issue_mask_out.

Issue (on issue_valid_out && issue_ready_in):
- pending &= ~issue_mask_out.
- Set busy for each nonzero dst with writes_dst set among the issued slots.
- Outputs must stay stable while valid && !ready.

Writeback:
- Each wb_valid_in clears busy[wb_reg_in]; a clear on an already-clear bit, or on register 0, is a no-op.
- Set and clear of the same register in one cycle cannot occur (the WAW check forbids it). If it does occur, set wins.
- busy[0] is always 0.

Flush:
- flush_in clears pending the next edge, overrides accept, and suppresses that cycle's issue handshake (issue_valid_out forced to 0).
- Busy bits are unaffected; writebacks still clear them.

Stall counter:
- Increments when pending != 0 and issue_mask_out == 0.
- Saturates at all-ones.

Test Plan:
- Reset mid-bundle: pending = 2'b11, busy[5] = 1, assert rst_in low between clock edges -> busy_out = 0, issue_valid_out = 0, stall_count_out = 0 immediately, without waiting for a clock edge.
- Independent pair: slot0 r3 <= r1+r2, slot1 r4 <= r1+r2, issue_ready_in = 1 -> one cycle after accept issue_mask_out = 2'b11; next cycle busy[3] = busy[4] = 1 and decode_ready_out = 1.
- Intra-bundle RAW: slot0 writes r7, slot1 reads r7 -> first issue mask 2'b01; slot1 held with mask 0 until wb r7; mask 2'b10 the cycle after the wb; stall_count_out = number of waiting cycles.
- WAW versus in-flight: busy[9] = 1, slot0 writes r9 -> mask 0 and decode_ready_out = 0; wb r9 -> issue on the next cycle.
- Register 0: slot0 writes r0, slot1 reads r0 -> mask 2'b11 and busy_out[0] stays 0.
- Back-pressure and flush: issue_ready_in = 0 for 3 cycles -> outputs stable and busy unchanged; then flush_in = 1 -> pending = 0 next cycle, issue_valid_out = 0, busy unchanged.

Source files
------------

// File: rtl/issue_scoreboard.sv
// Issue scoreboard: holds one decoded bundle, releases an in-order prefix of its
// slots once they are free of RAW/WAW hazards, and tracks per-register busy bits.
module issue_scoreboard #(
  parameter int unsigned WIDTH    = 2,
  parameter int unsigned REG_BITS = 6,
  parameter int unsigned NUM_REGS = 64,
  parameter int unsigned WB_PORTS = 2,
  parameter int unsigned CNT_BITS = 16
) (
  input  logic                         clk_in,
  input  logic                         rst_in,
  input  logic                         decode_valid_in,
  output logic                         decode_ready_out,
  input  logic [WIDTH-1:0]             dec_slot_valid_in,
  input  logic [WIDTH*REG_BITS-1:0]    dec_dst_in,
  input  logic [WIDTH*REG_BITS-1:0]    dec_src1_in,
  input  logic [WIDTH*REG_BITS-1:0]    dec_src2_in,
  input  logic [WIDTH*3-1:0]           dec_use_mask_in,
  input  logic                         issue_ready_in,
  output logic                         issue_valid_out,
  output logic [WIDTH-1:0]             issue_mask_out,
  output logic [WIDTH*REG_BITS-1:0]    issue_dst_out,
  output logic [WIDTH*REG_BITS-1:0]    issue_src1_out,
  output logic [WIDTH*REG_BITS-1:0]    issue_src2_out,
  input  logic [WB_PORTS-1:0]          wb_valid_in,
  input  logic [WB_PORTS*REG_BITS-1:0] wb_reg_in,
  input  logic                         flush_in,
  output logic [NUM_REGS-1:0]          busy_out,
  output logic [CNT_BITS-1:0]          stall_count_out
);

  logic [WIDTH-1:0]          r_pending;
  logic [WIDTH*REG_BITS-1:0] r_dst;
  logic [WIDTH*REG_BITS-1:0] r_src1;
  logic [WIDTH*REG_BITS-1:0] r_src2;
  logic [WIDTH*3-1:0]        r_use;
  logic [NUM_REGS-1:0]       r_busy;
  logic [CNT_BITS-1:0]       r_stall;

  logic [WIDTH-1:0]          w_clean;
  logic [WIDTH-1:0]          w_mask;
  logic                      w_fire;
  logic                      w_accept;
  logic [NUM_REGS-1:0]       w_busy_d;

  function automatic logic [REG_BITS-1:0] f_slot(input logic [WIDTH*REG_BITS-1:0] vec,
                                                 input int unsigned idx);
    return vec[idx*REG_BITS +: REG_BITS];
  endfunction

  // Per-slot hazard check against registered busy bits and earlier pending slots.
  always_comb begin
    w_clean = '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      w_clean[i] = r_pending[i];
      if (r_use[3*i] && f_slot(r_src1, i) != '0 && r_busy[f_slot(r_src1, i)]) w_clean[i] = 1'b0;
      if (r_use[3*i+1] && f_slot(r_src2, i) != '0 && r_busy[f_slot(r_src2, i)]) w_clean[i] = 1'b0;
      if (r_use[3*i+2] && f_slot(r_dst, i) != '0 && r_busy[f_slot(r_dst, i)]) w_clean[i] = 1'b0;
      for (int unsigned j = 0; j < i; j++) begin
        if (r_pending[j] && r_use[3*j+2] && f_slot(r_dst, j) != '0 &&
            ((r_use[3*i]   && f_slot(r_dst, j) == f_slot(r_src1, i)) ||
             (r_use[3*i+1] && f_slot(r_dst, j) == f_slot(r_src2, i)) ||
             (r_use[3*i+2] && f_slot(r_dst, j) == f_slot(r_dst, i)))) begin
          w_clean[i] = 1'b0;
        end
      end
    end
  end

  // Contiguous run of clean slots from the first pending slot; a gap or a dirty slot ends it.
  always_comb begin
    logic l_started;
    logic l_stop;
    w_mask    = '0;
    l_started = 1'b0;
    l_stop    = 1'b0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      if (!l_stop) begin
        if (r_pending[i]) begin
          l_started = 1'b1;
          if (w_clean[i]) w_mask[i] = 1'b1;
          else            l_stop    = 1'b1;
        end else if (l_started) begin
          l_stop = 1'b1;
        end
      end
    end
  end

  // Handshake outputs; flush suppresses issue for the cycle.
  always_comb begin
    issue_mask_out   = flush_in ? '0 : w_mask;
    issue_valid_out  = |issue_mask_out;
    w_fire           = issue_valid_out && issue_ready_in;
    decode_ready_out = (r_pending == '0) || (w_fire && (issue_mask_out == r_pending));
    w_accept         = decode_valid_in && decode_ready_out && !flush_in;
  end

  // Busy next state: writeback clears first so a same-cycle issue set wins.
  always_comb begin
    w_busy_d = r_busy;
    for (int unsigned p = 0; p < WB_PORTS; p++) begin
      if (wb_valid_in[p]) w_busy_d[wb_reg_in[p*REG_BITS +: REG_BITS]] = 1'b0;
    end
    if (w_fire) begin
      for (int unsigned i = 0; i < WIDTH; i++) begin
        if (issue_mask_out[i] && r_use[3*i+2]) w_busy_d[f_slot(r_dst, i)] = 1'b1;
      end
    end
    w_busy_d[0] = 1'b0;
  end

  // Held bundle and pending mask.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      r_pending <= '0;
      r_dst     <= '0;
      r_src1    <= '0;
      r_src2    <= '0;
      r_use     <= '0;
    end else if (flush_in) begin
      r_pending <= '0;
    end else if (w_accept) begin
      r_pending <= dec_slot_valid_in;
      r_dst     <= dec_dst_in;
      r_src1    <= dec_src1_in;
      r_src2    <= dec_src2_in;
      r_use     <= dec_use_mask_in;
    end else if (w_fire) begin
      r_pending <= r_pending & ~issue_mask_out;
    end
  end

  // Busy bit register.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) r_busy <= '0;
    else         r_busy <= w_busy_d;
  end

  // Saturating count of cycles with work held but nothing issuing.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      r_stall <= '0;
    end else if ((r_pending != '0) && (issue_mask_out == '0) && (r_stall != '1)) begin
      r_stall <= r_stall + CNT_BITS'(1);
    end
  end

  assign issue_dst_out   = r_dst;
  assign issue_src1_out  = r_src1;
  assign issue_src2_out  = r_src2;
  assign busy_out        = r_busy;
  assign stall_count_out = r_stall;

endmodule

// File: tb/tb_issue_scoreboard.sv
// Directed bench for issue_scoreboard with a per-cycle reference model.
module tb_issue_scoreboard;

  logic        clk_in = 1'b0;
  logic        rst_in = 1'b0;
  logic        decode_valid_in;
  logic        decode_ready_out;
  logic [1:0]  dec_slot_valid_in;
  logic [11:0] dec_dst_in, dec_src1_in, dec_src2_in;
  logic [5:0]  dec_use_mask_in;
  logic        issue_ready_in;
  logic        issue_valid_out;
  logic [1:0]  issue_mask_out;
  logic [11:0] issue_dst_out, issue_src1_out, issue_src2_out;
  logic [1:0]  wb_valid_in;
  logic [11:0] wb_reg_in;
  logic        flush_in;
  logic [63:0] busy_out;
  logic [15:0] stall_count_out;

  issue_scoreboard dut (
    .clk_in            (clk_in),
    .rst_in            (rst_in),
    .decode_valid_in   (decode_valid_in),
    .decode_ready_out  (decode_ready_out),
    .dec_slot_valid_in (dec_slot_valid_in),
    .dec_dst_in        (dec_dst_in),
    .dec_src1_in       (dec_src1_in),
    .dec_src2_in       (dec_src2_in),
    .dec_use_mask_in   (dec_use_mask_in),
    .issue_ready_in    (issue_ready_in),
    .issue_valid_out   (issue_valid_out),
    .issue_mask_out    (issue_mask_out),
    .issue_dst_out     (issue_dst_out),
    .issue_src1_out    (issue_src1_out),
    .issue_src2_out    (issue_src2_out),
    .wb_valid_in       (wb_valid_in),
    .wb_reg_in         (wb_reg_in),
    .flush_in          (flush_in),
    .busy_out          (busy_out),
    .stall_count_out   (stall_count_out)
  );

  always #5 clk_in = ~clk_in;

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model state: the held bundle as per-slot arrays plus a busy set.
  logic [1:0]  m_pend;
  logic [5:0]  m_dst [2];
  logic [5:0]  m_s1  [2];
  logic [5:0]  m_s2  [2];
  logic [2:0]  m_use [2];
  logic [63:0] m_busy;
  int          m_stall;
  bit          chk_en = 1'b0;

  task automatic reset_model();
    m_pend  = '0;
    m_busy  = '0;
    m_stall = 0;
    for (int i = 0; i < 2; i++) begin
      m_dst[i] = '0; m_s1[i] = '0; m_s2[i] = '0; m_use[i] = '0;
    end
  endtask

  function automatic logic reg_blocked(input logic used, input logic [5:0] r,
                                       input logic [63:0] claimed);
    return used && (r != 6'd0) && (m_busy[r] || claimed[r]);
  endfunction

  // Walk slots in program order; each issued writer claims its register for later slots.
  function automatic logic [1:0] model_mask();
    logic [63:0] claimed;
    logic        started, done;
    logic [1:0]  m;
    claimed = '0; started = 1'b0; done = 1'b0; m = '0;
    for (int i = 0; i < 2; i++) begin
      if (!done) begin
        if (!m_pend[i]) begin
          if (started) done = 1'b1;
        end else begin
          started = 1'b1;
          if (reg_blocked(m_use[i][0], m_s1[i], claimed) ||
              reg_blocked(m_use[i][1], m_s2[i], claimed) ||
              reg_blocked(m_use[i][2], m_dst[i], claimed)) begin
            done = 1'b1;
          end else begin
            m[i] = 1'b1;
            if (m_use[i][2] && m_dst[i] != 6'd0) claimed[m_dst[i]] = 1'b1;
          end
        end
      end
    end
    return m;
  endfunction

  task automatic model_step();
    logic [1:0]  mk, mo;
    logic        ev, er, fire, acc;
    logic [63:0] nb;
    mk   = model_mask();
    mo   = flush_in ? 2'b00 : mk;
    ev   = |mo;
    fire = ev && issue_ready_in;
    er   = (m_pend == 2'b00) || (fire && (mo == m_pend));
    chk("m_valid", issue_valid_out, ev);
    chk("m_mask", issue_mask_out, mo);
    chk("m_ready", decode_ready_out, er);
    chk("m_busy", busy_out, m_busy);
    chk("m_stall", stall_count_out, m_stall);
    chk("m_dst", issue_dst_out, {m_dst[1], m_dst[0]});
    chk("m_src1", issue_src1_out, {m_s1[1], m_s1[0]});
    chk("m_src2", issue_src2_out, {m_s2[1], m_s2[0]});
    acc = decode_valid_in && er && !flush_in;
    nb  = m_busy;
    for (int p = 0; p < 2; p++) if (wb_valid_in[p]) nb[wb_reg_in[p*6 +: 6]] = 1'b0;
    if (fire) for (int i = 0; i < 2; i++) if (mo[i] && m_use[i][2]) nb[m_dst[i]] = 1'b1;
    nb[0] = 1'b0;
    if (m_pend != 2'b00 && mo == 2'b00 && m_stall < 65535) m_stall++;
    m_busy = nb;
    if (flush_in) begin
      m_pend = 2'b00;
    end else if (acc) begin
      m_pend = dec_slot_valid_in;
      for (int i = 0; i < 2; i++) begin
        m_dst[i] = dec_dst_in[i*6 +: 6];
        m_s1[i]  = dec_src1_in[i*6 +: 6];
        m_s2[i]  = dec_src2_in[i*6 +: 6];
        m_use[i] = dec_use_mask_in[i*3 +: 3];
      end
    end else if (fire) begin
      m_pend = m_pend & ~mo;
    end
  endtask

  always @(negedge clk_in) begin
    if (rst_in && chk_en) model_step();
  end

  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  // Offer a bundle and hold it until accepted; returns just after the accepting edge.
  task automatic offer(input logic [1:0] sv,
                       input logic [5:0] d0, input logic [5:0] a0, input logic [5:0] b0,
                       input logic [2:0] u0,
                       input logic [5:0] d1, input logic [5:0] a1, input logic [5:0] b1,
                       input logic [2:0] u1);
    logic ok;
    decode_valid_in   = 1'b1;
    dec_slot_valid_in = sv;
    dec_dst_in        = {d1, d0};
    dec_src1_in       = {a1, a0};
    dec_src2_in       = {b1, b0};
    dec_use_mask_in   = {u1, u0};
    ok = 1'b0;
    for (int k = 0; k < 20 && !ok; k++) begin
      @(negedge clk_in);
      if (decode_ready_out && !flush_in) ok = 1'b1;
      step();
    end
    chk("offer_accept", ok, 1'b1);
    decode_valid_in = 1'b0;
  endtask

  task automatic wb_one(input logic [5:0] r);
    wb_valid_in = 2'b01;
    wb_reg_in   = {6'd0, r};
    step();
    wb_valid_in = 2'b00;
  endtask

  initial begin
    reset_model();
    decode_valid_in   = 1'b0;
    dec_slot_valid_in = '0;
    dec_dst_in        = '0;
    dec_src1_in       = '0;
    dec_src2_in       = '0;
    dec_use_mask_in   = '0;
    issue_ready_in    = 1'b1;
    wb_valid_in       = '0;
    wb_reg_in         = '0;
    flush_in          = 1'b0;
    repeat (2) @(posedge clk_in);
    #2 rst_in = 1'b1;
    chk_en = 1'b1;
    @(negedge clk_in);
    chk("rst_ready", decode_ready_out, 1'b1);
    chk("rst_valid", issue_valid_out, 1'b0);
    chk("rst_stall", stall_count_out, 16'd0);
    step();

    // Reset mid-bundle: r5 busy, bundle {r7<=r1, r6<=r5} stuck pending.
    offer(2'b01, 6'd5, 6'd0, 6'd0, 3'b100, 6'd0, 6'd0, 6'd0, 3'b000);
    offer(2'b11, 6'd6, 6'd5, 6'd0, 3'b101, 6'd7, 6'd1, 6'd0, 3'b101);
    @(negedge clk_in);
    chk("rm_mask", issue_mask_out, 2'b00);
    chk("rm_busy5", busy_out[5], 1'b1);
    @(posedge clk_in);
    #2 rst_in = 1'b0;
    #1;
    chk("rm_busy", busy_out, 64'd0);
    chk("rm_valid", issue_valid_out, 1'b0);
    chk("rm_stall", stall_count_out, 16'd0);
    chk("rm_ready", decode_ready_out, 1'b1);
    reset_model();
    @(posedge clk_in);
    #2 rst_in = 1'b1;
    step();

    // Independent pair.
    offer(2'b11, 6'd3, 6'd1, 6'd2, 3'b111, 6'd4, 6'd1, 6'd2, 3'b111);
    @(negedge clk_in);
    chk("ip_mask", issue_mask_out, 2'b11);
    step();
    @(negedge clk_in);
    chk("ip_busy3", busy_out[3], 1'b1);
    chk("ip_busy4", busy_out[4], 1'b1);
    chk("ip_ready", decode_ready_out, 1'b1);
    step();
    wb_valid_in = 2'b11;
    wb_reg_in   = {6'd4, 6'd3};
    step();
    wb_valid_in = 2'b00;
    @(negedge clk_in);
    chk("ip_wb_clear", busy_out, 64'd0);
    step();

    // Intra-bundle RAW: r7 <= r1+r2 ; r8 <= r7+r1.
    offer(2'b11, 6'd7, 6'd1, 6'd2, 3'b111, 6'd8, 6'd7, 6'd1, 3'b111);
    @(negedge clk_in);
    chk("raw_first", issue_mask_out, 2'b01);
    step();
    @(negedge clk_in);
    chk("raw_wait1", issue_mask_out, 2'b00);
    step();
    @(negedge clk_in);
    chk("raw_wait2", issue_mask_out, 2'b00);
    step();
    wb_valid_in = 2'b01;
    wb_reg_in   = {6'd0, 6'd7};
    @(negedge clk_in);
    chk("raw_wait3", issue_mask_out, 2'b00);
    step();
    wb_valid_in = 2'b00;
    @(negedge clk_in);
    chk("raw_second", issue_mask_out, 2'b10);
    chk("raw_stall", stall_count_out, 16'd3);
    step();
    wb_one(6'd8);

    // WAW against an in-flight writer of r9.
    offer(2'b01, 6'd9, 6'd0, 6'd0, 3'b100, 6'd0, 6'd0, 6'd0, 3'b000);
    offer(2'b01, 6'd9, 6'd0, 6'd0, 3'b100, 6'd0, 6'd0, 6'd0, 3'b000);
    @(negedge clk_in);
    chk("waw_mask", issue_mask_out, 2'b00);
    chk("waw_ready", decode_ready_out, 1'b0);
    chk("waw_busy9", busy_out[9], 1'b1);
    step();
    wb_valid_in = 2'b10;
    wb_reg_in   = {6'd9, 6'd0};
    @(negedge clk_in);
    chk("waw_hold", issue_mask_out, 2'b00);
    step();
    wb_valid_in = 2'b00;
    @(negedge clk_in);
    chk("waw_release", issue_mask_out, 2'b01);
    step();
    wb_one(6'd9);

    // Register 0 never creates a hazard and never becomes busy.
    offer(2'b11, 6'd0, 6'd1, 6'd2, 3'b111, 6'd10, 6'd0, 6'd0, 3'b111);
    @(negedge clk_in);
    chk("r0_mask", issue_mask_out, 2'b11);
    step();
    @(negedge clk_in);
    chk("r0_busy0", busy_out[0], 1'b0);
    chk("r0_busy10", busy_out[10], 1'b1);
    step();
    wb_one(6'd10);

    // Empty bundle is accepted and dropped.
    offer(2'b00, 6'd13, 6'd14, 6'd15, 3'b111, 6'd13, 6'd14, 6'd15, 3'b111);
    @(negedge clk_in);
    chk("drop_valid", issue_valid_out, 1'b0);
    chk("drop_ready", decode_ready_out, 1'b1);
    step();

    // Back-pressure then flush.
    issue_ready_in = 1'b0;
    offer(2'b11, 6'd11, 6'd1, 6'd2, 3'b111, 6'd12, 6'd1, 6'd2, 3'b111);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk_in);
      chk("bp_valid", issue_valid_out, 1'b1);
      chk("bp_mask", issue_mask_out, 2'b11);
      chk("bp_dst", issue_dst_out, {6'd12, 6'd11});
      chk("bp_busy", busy_out, 64'd0);
      step();
    end
    flush_in = 1'b1;
    @(negedge clk_in);
    chk("fl_valid", issue_valid_out, 1'b0);
    step();
    flush_in       = 1'b0;
    issue_ready_in = 1'b1;
    @(negedge clk_in);
    chk("fl_after_valid", issue_valid_out, 1'b0);
    chk("fl_after_ready", decode_ready_out, 1'b1);
    chk("fl_after_busy", busy_out, 64'd0);
    repeat (3) step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
